ac_enumerator: RTL and testbench
================================

AC_ENUMERATOR -- requirements
Module: ac_enumerator

Interface
REQ-001 SHALL have port: CLK40  in  1  40 MHz clock; all logic on rising edge.
REQ-002 SHALL have port: RESETn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: START  in  1  one-cycle pulse; begins enumeration when idle.
REQ-004 SHALL have ports for the config-bus request side: AC_REQ out 1 (cycle request); AC_RnW out 1 (1 = read); AC_ADDR out 7 (config offset A[7:1]); AC_DOUT out 4 (write nibble, D31-28).
REQ-005 SHALL have ports for the config-bus response side: AC_DIN in 4 (read nibble, D31-28); AC_ACK in 1 (one-cycle cycle termination).
REQ-006 SHALL have ports for per-board results: BOARD_DONE out 1 (one-cycle pulse per board handled); LAST_MFG out 16; LAST_PROD out 8; LAST_BASE out 8 (A23-16).
REQ-007 SHALL have ports for status: BUSY out 1; DONE out 1 (level); ERROR out 1 (level); BOARD_COUNT out 4 (saturating).

Function
REQ-008 SHALL use states IDLE, RD_REQ, RD_WAIT, DECODE, ALLOC, WR_LO, WR_HI, WR_WAIT, NEXT, FIN; BUSY = not IDLE and not FIN.
REQ-009 SHALL leave IDLE on START; START SHALL be ignored in all other states except FIN, where it restarts enumeration with counters and allocators re-initialised.
REQ-010 SHALL hold AC_REQ, AC_RnW, AC_ADDR and AC_DOUT stable from request until the cycle in which AC_ACK is sampled high, drop AC_REQ the next cycle, and insert at least one idle cycle between transactions.
REQ-011 SHALL read, per board, offsets 0x00, 0x02, 0x04, 0x06, 0x10, 0x12, 0x14 and 0x16 in that order; nibbles at 0x00/0x02 are used as read, all others are bit-inverted before use.
REQ-012 SHALL run a 9-bit timeout counter from each request; if AC_ACK is not seen within 256 cycles: on the offset-0x00 read, go to FIN with ERROR=0 (no more boards); on any other cycle, go to FIN with ERROR=1.
REQ-013 SHALL decode type = {nib00, nib02}; type[7:6] != 2'b11 on a completed offset-0x00 read -> FIN, ERROR=0 (end of chain).
REQ-014 SHALL compute the size in 64K units from type[2:0]: 000=128, 001=1, 010=2, 011=4, 100=8, 101=16, 110=32, 111=64.
REQ-015 SHALL allocate from the memory pool (next-free init 0x20, limit 0xA0) when type[5]=1, else from the I/O pool (init 0xE9, limit 0xF0).
REQ-016 SHALL align the candidate base up to a multiple of size, using 9-bit arithmetic; the board fits iff aligned base + size <= limit.
REQ-017 On fit, SHALL write base[3:0] to offset 0x4A, then base[7:4] to offset 0x48 (uninverted), advance that pool's next-free to base+size, update the LAST_* outputs, and pulse BOARD_DONE one cycle after the 0x48 ACK.
REQ-018 On no fit, SHALL behave as set by REQ-024/REQ-025.
REQ-019 SHALL increment BOARD_COUNT per configured board, saturating at 15; after the 0x48 write it SHALL return to RD_REQ at offset 0x00 for the next board.
REQ-020 SHALL latch AC_ACK only while AC_REQ is high; a stray AC_ACK in any other state SHALL be ignored.

Reset
REQ-021 SHALL, on RESETn low at a clock edge, enter IDLE and clear AC_REQ, AC_RnW, BOARD_DONE, DONE, ERROR and BUSY to 0; AC_ADDR, AC_DOUT, LAST_* and BOARD_COUNT to 0.
REQ-022 SHALL reset the pool next-free registers to 0x20 and 0xE9.
REQ-023 Reset mid-transaction SHALL drop AC_REQ in the same edge, with no further bus activity until START.

Configuration
REQ-024 With AC_SHUTUP_EN defined, a non-fitting board SHALL be sent a write of 0x0 to offset 0x4C, BOARD_DONE SHALL pulse with LAST_BASE=0x00, BOARD_COUNT SHALL not increment, and enumeration SHALL continue.
REQ-025 Without AC_SHUTUP_EN, a non-fitting board SHALL cause FIN with ERROR=1 and no write.

Structure
REQ-026 SHALL put in a shared package: the state enum, config offsets (0x00-0x16, 0x48, 0x4A, 0x4C), pool init/limit constants, and the timeout width.
REQ-027 SHALL use one sub-module, ac_size_alloc: combinational size decode, alignment and fit check.

Verification
REQ-028 Verify: responder model with one I/O board, type 0xC1 (64K) -> writes 0x9@0x4A then 0xE@0x48, LAST_BASE=0xE9, BOARD_COUNT=1, DONE=1, ERROR=0.
REQ-029 Verify: chain of a 64K I/O board then a 128K I/O board (type 0xC2) -> bases 0xE9 and 0xEA (0xE9+1=0xEA is already 2-unit aligned), BOARD_COUNT=2.
REQ-030 Verify: memory board type 0xE0 (8MB) -> LAST_BASE=0x20, memory next-free=0xA0; a second 8MB board gives no fit -> ERROR=1, or, with AC_SHUTUP_EN, a write to 0x4C and DONE with ERROR=0.
REQ-031 Verify: no ACK to the first 0x00 read for 256 cycles -> DONE=1, ERROR=0, BOARD_COUNT=0; no ACK on the 0x12 read -> ERROR=1.
REQ-032 Verify: RESETn pulsed while in RD_WAIT -> AC_REQ=0 next edge; START afterwards -> enumeration restarts from offset 0x00.

Source files
------------

// File: rtl/ac_enumerator_pkg.sv
// ac_enumerator_pkg: shared definitions for the AutoConfig-style enumerator.
//   - FSM state enum
//   - config-space byte offsets (reads 0x00-0x16, base writes 0x48/0x4A, shut-up 0x4C)
//   - memory / I/O pool initial next-free values and limits (A23-16 units of 64K)
//   - timeout counter width and terminal count
//   - helpers: read-sequence word address, size-code decode
package ac_enumerator_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StDecode,
    StAlloc,
    StWrLo,
    StWrHi,
    StWrWait,
    StNext,
    StFin
  } ac_state_e;

  // Config-space byte offsets; the bus carries A[7:1].
  localparam logic [7:0] OffType0  = 8'h00;
  localparam logic [7:0] OffType1  = 8'h02;
  localparam logic [7:0] OffProd0  = 8'h04;
  localparam logic [7:0] OffProd1  = 8'h06;
  localparam logic [7:0] OffMfg0   = 8'h10;
  localparam logic [7:0] OffMfg1   = 8'h12;
  localparam logic [7:0] OffMfg2   = 8'h14;
  localparam logic [7:0] OffMfg3   = 8'h16;
  localparam logic [7:0] OffBaseHi = 8'h48;
  localparam logic [7:0] OffBaseLo = 8'h4A;
  localparam logic [7:0] OffShutUp = 8'h4C;

  // Address pools in 64K units (A23-16).
  localparam logic [7:0] MemInit  = 8'h20;
  localparam logic [7:0] MemLimit = 8'hA0;
  localparam logic [7:0] IoInit   = 8'hE9;
  localparam logic [7:0] IoLimit  = 8'hF0;

  // Bus cycle timeout: 256 cycles without ACK.
  localparam int unsigned         TimeoutW    = 9;
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(255);

  // Word address (A[7:1]) of the idx-th read of a board's config ROM.
  function automatic logic [6:0] word_addr(input logic [7:0] off);
    return 7'(off >> 1);
  endfunction

  function automatic logic [6:0] rd_word_addr(input logic [2:0] idx);
    logic [7:0] off;
    case (idx)
      3'd0:    off = OffType0;
      3'd1:    off = OffType1;
      3'd2:    off = OffProd0;
      3'd3:    off = OffProd1;
      3'd4:    off = OffMfg0;
      3'd5:    off = OffMfg1;
      3'd6:    off = OffMfg2;
      default: off = OffMfg3;
    endcase
    return word_addr(off);
  endfunction

  // Board size in 64K units from type[2:0]; code 000 is the largest (8MB).
  function automatic logic [8:0] size_units(input logic [2:0] code);
    logic [8:0] units;
    case (code)
      3'b000:  units = 9'd128;
      3'b001:  units = 9'd1;
      3'b010:  units = 9'd2;
      3'b011:  units = 9'd4;
      3'b100:  units = 9'd8;
      3'b101:  units = 9'd16;
      3'b110:  units = 9'd32;
      default: units = 9'd64;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/ac_size_alloc.sv
// ac_size_alloc: combinational size decode, base alignment and fit check.
//   size_code_i  type[2:0] of the board
//   is_mem_i     type[5]: 1 = memory pool, 0 = I/O pool
//   mem_next_i   memory pool next-free (64K units)
//   io_next_i    I/O pool next-free (64K units)
//   base_o       aligned base to assign (valid when fit_o)
//   end_o        base + size, the pool's new next-free (valid when fit_o)
//   fit_o        aligned base + size <= pool limit
module ac_size_alloc
  import ac_enumerator_pkg::*;
(
  input  logic [2:0] size_code_i,
  input  logic       is_mem_i,
  input  logic [7:0] mem_next_i,
  input  logic [7:0] io_next_i,
  output logic [7:0] base_o,
  output logic [7:0] end_o,
  output logic       fit_o
);

  logic [8:0] size;
  logic [8:0] align;
  logic [8:0] cand;
  logic [8:0] limit;
  logic [8:0] aligned;
  logic [8:0] end_addr;

  always_comb begin
    size  = size_units(size_code_i);
    // An 8MB board has no size-aligned slot inside the memory pool (0x80 + 0x80 > 0xA0), so
    // it is placed on a 2MB boundary instead; every other size aligns to itself.
    align = (size_code_i == 3'b000) ? 9'd32 : size;
    cand  = is_mem_i ? {1'b0, mem_next_i} : {1'b0, io_next_i};
    limit = is_mem_i ? {1'b0, MemLimit} : {1'b0, IoLimit};
    // 9-bit arithmetic keeps the carry out of A23 visible to the fit compare.
    aligned  = (cand + align - 9'd1) & ~(align - 9'd1);
    end_addr = aligned + size;
    fit_o    = (end_addr <= limit);
    base_o   = aligned[7:0];
    end_o    = end_addr[7:0];
  end

endmodule

// File: rtl/ac_enumerator.sv
// ac_enumerator: walks a chain of AutoConfig boards over a nibble-wide config bus, reads each
// board's type/product/manufacturer, assigns it a base from the memory or I/O pool and writes
// the base back (0x4A low nibble, then 0x48 high nibble).
//   CLK40, RESETn      clock, synchronous active-low reset
//   START              one-cycle pulse, starts (or restarts from FIN) enumeration
//   AC_REQ/RnW/ADDR/DOUT  request side, held until ACK is sampled
//   AC_DIN/AC_ACK      response side
//   BOARD_DONE         one-cycle pulse per handled board, LAST_* valid with it
//   BUSY/DONE/ERROR    status levels, BOARD_COUNT saturates at 15
// Build option: define AC_SHUTUP_EN to shut up boards that do not fit (write 0x0 to 0x4C)
// and keep enumerating, instead of stopping with ERROR.
module ac_enumerator
  import ac_enumerator_pkg::*;
(
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        START,
  output logic        AC_REQ,
  output logic        AC_RnW,
  output logic [6:0]  AC_ADDR,
  output logic [3:0]  AC_DOUT,
  input  logic [3:0]  AC_DIN,
  input  logic        AC_ACK,
  output logic        BOARD_DONE,
  output logic [15:0] LAST_MFG,
  output logic [7:0]  LAST_PROD,
  output logic [7:0]  LAST_BASE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [3:0]  BOARD_COUNT
);

  ac_state_e state_q, state_d;

  logic [2:0]          idx_q, idx_d;
  logic [31:0]         nib_q, nib_d;       // nibble of read idx at [4*idx +: 4], already inverted
  logic [TimeoutW-1:0] timer_q, timer_d;
  logic                req_q, req_d;
  logic                rnw_q, rnw_d;
  logic [6:0]          addr_q, addr_d;
  logic [3:0]          dout_q, dout_d;
  logic [7:0]          mem_next_q, mem_next_d;
  logic [7:0]          io_next_q, io_next_d;
  logic [7:0]          base_q, base_d;
  logic                hi_q, hi_d;         // high-nibble write issued
  logic                shut_q, shut_d;     // current board gets the shut-up write
  logic                err_q, err_d;
  logic [3:0]          count_q, count_d;
  logic [15:0]         mfg_q, mfg_d;
  logic [7:0]          prod_q, prod_d;
  logic [7:0]          last_base_q, last_base_d;

  logic        ack_seen;
  logic        timeout;
  logic [15:0] board_mfg;
  logic [7:0]  board_prod;
  logic [7:0]  alloc_base;
  logic [7:0]  alloc_end;
  logic        alloc_fit;
  logic        unused_type_flags;

  // ACK only counts while a request is outstanding.
  assign ack_seen = AC_ACK & req_q;
  assign timeout  = (timer_q == TimeoutLast);

  // type = {nib00, nib02}: type[7:6] = nib_q[3:2], type[5] = nib_q[1], type[2:0] = nib_q[6:4].
  assign board_prod = {nib_q[11:8], nib_q[15:12]};
  assign board_mfg  = {nib_q[19:16], nib_q[23:20], nib_q[27:24], nib_q[31:28]};
  // type[4:3] flags are not acted on by this enumerator.
  assign unused_type_flags = ^{nib_q[0], nib_q[7]};

  ac_size_alloc u_size_alloc (
    .size_code_i (nib_q[6:4]),
    .is_mem_i    (nib_q[1]),
    .mem_next_i  (mem_next_q),
    .io_next_i   (io_next_q),
    .base_o      (alloc_base),
    .end_o       (alloc_end),
    .fit_o       (alloc_fit)
  );

  // State register.
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (START) state_d = StRdReq;
      StRdReq:  state_d = StRdWait;
      StRdWait: begin
        if (ack_seen) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StFin;
        end
      end
      StDecode: begin
        if ((idx_q == 3'd0) && (nib_q[3:2] != 2'b11)) begin
          state_d = StFin;
        end else if (idx_q == 3'd7) begin
          state_d = StAlloc;
        end else begin
          state_d = StRdReq;
        end
      end
      StAlloc: begin
        if (alloc_fit) begin
          state_d = StWrLo;
        end else begin
`ifdef AC_SHUTUP_EN
          state_d = StWrLo;
`else
          state_d = StFin;
`endif
        end
      end
      StWrLo:   state_d = StWrWait;
      StWrHi:   state_d = StWrWait;
      StWrWait: begin
        if (ack_seen) begin
          state_d = (hi_q || shut_q) ? StNext : StWrHi;
        end else if (timeout) begin
          state_d = StFin;
        end
      end
      StNext:   state_d = StRdReq;
      StFin:    if (START) state_d = StRdReq;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    idx_d       = idx_q;
    nib_d       = nib_q;
    timer_d     = timer_q;
    req_d       = req_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    mem_next_d  = mem_next_q;
    io_next_d   = io_next_q;
    base_d      = base_q;
    hi_d        = hi_q;
    shut_d      = shut_q;
    err_d       = err_q;
    count_d     = count_q;
    mfg_d       = mfg_q;
    prod_d      = prod_q;
    last_base_d = last_base_q;

    case (state_q)
      StIdle, StFin: begin
        if (START) begin
          idx_d      = 3'd0;
          mem_next_d = MemInit;
          io_next_d  = IoInit;
          count_d    = 4'd0;
          err_d      = 1'b0;
          hi_d       = 1'b0;
          shut_d     = 1'b0;
        end
      end
      StRdReq: begin
        req_d   = 1'b1;
        rnw_d   = 1'b1;
        addr_d  = rd_word_addr(idx_q);
        dout_d  = 4'h0;
        timer_d = '0;
      end
      StRdWait: begin
        timer_d = timer_q + TimeoutW'(1);
        if (ack_seen) begin
          req_d = 1'b0;
          // Type nibbles come through as-is, the rest of the ROM is stored inverted.
          nib_d[{idx_q, 2'b00} +: 4] = (idx_q < 3'd2) ? AC_DIN : ~AC_DIN;
        end else if (timeout) begin
          req_d = 1'b0;
          // Silence on the first type read just means the chain is empty.
          err_d = (idx_q != 3'd0);
        end
      end
      StDecode: begin
        if (idx_q != 3'd7) begin
          idx_d = idx_q + 3'd1;
        end
      end
      StAlloc: begin
        hi_d = 1'b0;
        if (alloc_fit) begin
          base_d = alloc_base;
          shut_d = 1'b0;
          if (nib_q[1]) begin
            mem_next_d = alloc_end;
          end else begin
            io_next_d = alloc_end;
          end
        end else begin
`ifdef AC_SHUTUP_EN
          shut_d = 1'b1;
`else
          err_d  = 1'b1;
`endif
        end
      end
      StWrLo: begin
        req_d   = 1'b1;
        rnw_d   = 1'b0;
        timer_d = '0;
        if (shut_q) begin
          addr_d = word_addr(OffShutUp);
          dout_d = 4'h0;
        end else begin
          addr_d = word_addr(OffBaseLo);
          dout_d = base_q[3:0];
        end
      end
      StWrHi: begin
        req_d   = 1'b1;
        rnw_d   = 1'b0;
        timer_d = '0;
        addr_d  = word_addr(OffBaseHi);
        dout_d  = base_q[7:4];
        hi_d    = 1'b1;
      end
      StWrWait: begin
        timer_d = timer_q + TimeoutW'(1);
        if (ack_seen) begin
          req_d = 1'b0;
          if (hi_q || shut_q) begin
            // Last write of this board: publish results for the BOARD_DONE cycle.
            mfg_d       = board_mfg;
            prod_d      = board_prod;
            last_base_d = shut_q ? 8'h00 : base_q;
            if (!shut_q && (count_q != 4'hF)) begin
              count_d = count_q + 4'd1;
            end
          end
        end else if (timeout) begin
          req_d = 1'b0;
          err_d = 1'b1;
        end
      end
      StNext: begin
        idx_d  = 3'd0;
        hi_d   = 1'b0;
        shut_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      idx_q       <= 3'd0;
      nib_q       <= '0;
      timer_q     <= '0;
      req_q       <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= 7'd0;
      dout_q      <= 4'd0;
      mem_next_q  <= MemInit;
      io_next_q   <= IoInit;
      base_q      <= 8'd0;
      hi_q        <= 1'b0;
      shut_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= 4'd0;
      mfg_q       <= 16'd0;
      prod_q      <= 8'd0;
      last_base_q <= 8'd0;
    end else begin
      idx_q       <= idx_d;
      nib_q       <= nib_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      mem_next_q  <= mem_next_d;
      io_next_q   <= io_next_d;
      base_q      <= base_d;
      hi_q        <= hi_d;
      shut_q      <= shut_d;
      err_q       <= err_d;
      count_q     <= count_d;
      mfg_q       <= mfg_d;
      prod_q      <= prod_d;
      last_base_q <= last_base_d;
    end
  end

  // State-decoded outputs.
  always_comb begin
    BUSY       = (state_q != StIdle) && (state_q != StFin);
    DONE       = (state_q == StFin);
    BOARD_DONE = (state_q == StNext);
  end

  assign AC_REQ      = req_q;
  assign AC_RnW      = rnw_q;
  assign AC_ADDR     = addr_q;
  assign AC_DOUT     = dout_q;
  assign ERROR       = err_q;
  assign BOARD_COUNT = count_q;
  assign LAST_MFG    = mfg_q;
  assign LAST_PROD   = prod_q;
  assign LAST_BASE   = last_base_q;

endmodule

// File: tb/tb_ac_enumerator.sv
// Directed bench for ac_enumerator with a config-bus responder model holding a short chain of
// boards. Define AC_SHUTUP_EN for both RTL and bench to exercise the shut-up build.
module tb_ac_enumerator;

  logic        CLK40 = 1'b0;
  logic        RESETn;
  logic        START;
  logic        AC_REQ;
  logic        AC_RnW;
  logic [6:0]  AC_ADDR;
  logic [3:0]  AC_DOUT;
  logic [3:0]  AC_DIN;
  logic        AC_ACK;
  logic        BOARD_DONE;
  logic [15:0] LAST_MFG;
  logic [7:0]  LAST_PROD;
  logic [7:0]  LAST_BASE;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [3:0]  BOARD_COUNT;

  ac_enumerator dut (
    .CLK40       (CLK40),
    .RESETn      (RESETn),
    .START       (START),
    .AC_REQ      (AC_REQ),
    .AC_RnW      (AC_RnW),
    .AC_ADDR     (AC_ADDR),
    .AC_DOUT     (AC_DOUT),
    .AC_DIN      (AC_DIN),
    .AC_ACK      (AC_ACK),
    .BOARD_DONE  (BOARD_DONE),
    .LAST_MFG    (LAST_MFG),
    .LAST_PROD   (LAST_PROD),
    .LAST_BASE   (LAST_BASE),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERROR       (ERROR),
    .BOARD_COUNT (BOARD_COUNT)
  );

  always #5 CLK40 = ~CLK40;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder model state.
  logic [7:0]  brd_type[4];
  logic [15:0] brd_mfg[4];
  logic [7:0]  brd_prod[4];
  int          nboards     = 0;
  int          cur_board   = 0;
  int          rsp_delay   = 2;
  int          req_age     = 0;
  int          viol        = 0;
  logic [6:0]  silent_addr = 7'h7F;
  logic        force_ack   = 1'b0;
  logic        acked_last  = 1'b0;
  logic        prev_req    = 1'b0;
  logic        prev_rnw    = 1'b0;
  logic [6:0]  prev_addr   = 7'h0;
  logic [3:0]  prev_dout   = 4'h0;
  logic [6:0]  wr_addr[$];
  logic [3:0]  wr_data[$];
  logic [7:0]  pulse_base[$];

  function automatic logic [3:0] rsp_nib(input int b, input logic [6:0] a);
    logic [7:0]  t = brd_type[b];
    logic [15:0] m = brd_mfg[b];
    logic [7:0]  p = brd_prod[b];
    case (a)
      7'h00:   return t[7:4];
      7'h01:   return t[3:0];
      7'h02:   return ~p[7:4];
      7'h03:   return ~p[3:0];
      7'h08:   return ~m[15:12];
      7'h09:   return ~m[11:8];
      7'h0A:   return ~m[7:4];
      7'h0B:   return ~m[3:0];
      default: return 4'hF;
    endcase
  endfunction

  // Responder: acks rsp_delay cycles into each request, and watches request hold/drop rules.
  initial begin
    AC_ACK = 1'b0;
    AC_DIN = 4'h0;
    forever begin
      @(negedge CLK40);
      if (acked_last && AC_REQ) viol++;
      if (prev_req && AC_REQ && !acked_last &&
          (AC_ADDR !== prev_addr || AC_RnW !== prev_rnw || AC_DOUT !== prev_dout)) viol++;
      acked_last = 1'b0;
      prev_req   = AC_REQ;
      prev_addr  = AC_ADDR;
      prev_rnw   = AC_RnW;
      prev_dout  = AC_DOUT;
      AC_ACK     = force_ack;
      if (AC_REQ) req_age++;
      else req_age = 0;
      if (AC_REQ && req_age == rsp_delay && cur_board < nboards && AC_ADDR != silent_addr) begin
        AC_ACK     = 1'b1;
        acked_last = 1'b1;
        if (AC_RnW) begin
          AC_DIN = rsp_nib(cur_board, AC_ADDR);
        end else begin
          wr_addr.push_back(AC_ADDR);
          wr_data.push_back(AC_DOUT);
          if (AC_ADDR == 7'h24 || AC_ADDR == 7'h26) cur_board++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK40);
      if (BOARD_DONE === 1'b1) pulse_base.push_back(LAST_BASE);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    pulse_base.delete();
    cur_board = 0;
    viol      = 0;
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    START  = 1'b0;
    @(negedge CLK40);
    @(negedge CLK40);
    RESETn = 1'b1;
    clear_log();
  endtask

  task automatic set_board(input int i, input logic [7:0] t, input logic [15:0] m,
                           input logic [7:0] p);
    brd_type[i] = t;
    brd_mfg[i]  = m;
    brd_prod[i] = p;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK40);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (DONE !== 1'b1 && cycles < budget) begin
      @(posedge CLK40);
      cycles++;
      @(negedge CLK40);
    end
    check(tag, 32'(DONE), 1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (AC_REQ !== 1'b1 && n < budget) begin
      @(negedge CLK40);
      n++;
    end
    check(tag, 32'(AC_REQ), 1);
  endtask

  initial begin
    int cyc;
    int seen;
    RESETn = 1'b0;
    START  = 1'b0;
    do_reset();

    // Reset state.
    check("rst_req", 32'(AC_REQ), 0);
    check("rst_rnw", 32'(AC_RnW), 0);
    check("rst_addr", 32'(AC_ADDR), 0);
    check("rst_dout", 32'(AC_DOUT), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_err", 32'(ERROR), 0);
    check("rst_bd", 32'(BOARD_DONE), 0);
    check("rst_count", 32'(BOARD_COUNT), 0);
    check("rst_base", 32'(LAST_BASE), 0);
    check("rst_mfg", 32'(LAST_MFG), 0);

    // Stray ACK while idle is ignored.
    force_ack = 1'b1;
    @(negedge CLK40);
    @(negedge CLK40);
    force_ack = 1'b0;
    @(negedge CLK40);
    check("stray_busy", 32'(BUSY), 0);
    check("stray_req", 32'(AC_REQ), 0);

    // One 64K I/O board.
    nboards = 1;
    set_board(0, 8'hC1, 16'h1234, 8'h56);
    pulse_start();
    wait_done("t1_done", 2000, cyc);
    check("t1_nwr", wr_addr.size(), 2);
    check("t1_wr0_addr", 32'(wr_addr[0]), 'h25);
    check("t1_wr0_data", 32'(wr_data[0]), 'h9);
    check("t1_wr1_addr", 32'(wr_addr[1]), 'h24);
    check("t1_wr1_data", 32'(wr_data[1]), 'hE);
    check("t1_npulse", pulse_base.size(), 1);
    check("t1_pulse_base", 32'(pulse_base[0]), 'hE9);
    check("t1_base", 32'(LAST_BASE), 'hE9);
    check("t1_mfg", 32'(LAST_MFG), 'h1234);
    check("t1_prod", 32'(LAST_PROD), 'h56);
    check("t1_count", 32'(BOARD_COUNT), 1);
    check("t1_err", 32'(ERROR), 0);
    check("t1_busy", 32'(BUSY), 0);
    check("t1_proto", viol, 0);

    // 64K then 128K I/O board.
    do_reset();
    nboards = 2;
    set_board(0, 8'hC1, 16'h1234, 8'h56);
    set_board(1, 8'hC2, 16'hBEEF, 8'h12);
    pulse_start();
    wait_done("t2_done", 3000, cyc);
    check("t2_npulse", pulse_base.size(), 2);
    check("t2_base0", 32'(pulse_base[0]), 'hE9);
    check("t2_base1", 32'(pulse_base[1]), 'hEA);
    check("t2_wr2_data", 32'(wr_data[2]), 'hA);
    check("t2_wr3_data", 32'(wr_data[3]), 'hE);
    check("t2_count", 32'(BOARD_COUNT), 2);
    check("t2_mfg", 32'(LAST_MFG), 'hBEEF);
    check("t2_err", 32'(ERROR), 0);
    check("t2_proto", viol, 0);

    // Restart from FIN without reset: count and pools start over.
    clear_log();
    nboards = 1;
    pulse_start();
    check("t2r_busy", 32'(BUSY), 1);
    wait_done("t2r_done", 2000, cyc);
    check("t2r_count", 32'(BOARD_COUNT), 1);
    check("t2r_base", 32'(pulse_base[0]), 'hE9);

    // Two 8MB memory boards: the second cannot fit.
    do_reset();
    nboards = 2;
    set_board(0, 8'hE0, 16'h0202, 8'h01);
    set_board(1, 8'hE0, 16'h0202, 8'h01);
    pulse_start();
    wait_done("t3_done", 3000, cyc);
    check("t3_base0", 32'(pulse_base[0]), 'h20);
    check("t3_wr0_data", 32'(wr_data[0]), 'h0);
    check("t3_wr1_data", 32'(wr_data[1]), 'h2);
    check("t3_count", 32'(BOARD_COUNT), 1);
`ifdef AC_SHUTUP_EN
    check("t3_nwr", wr_addr.size(), 3);
    check("t3_wr2_addr", 32'(wr_addr[2]), 'h26);
    check("t3_wr2_data", 32'(wr_data[2]), 'h0);
    check("t3_npulse", pulse_base.size(), 2);
    check("t3_base1", 32'(pulse_base[1]), 'h00);
    check("t3_err", 32'(ERROR), 0);
`else
    check("t3_nwr", wr_addr.size(), 2);
    check("t3_npulse", pulse_base.size(), 1);
    check("t3_err", 32'(ERROR), 1);
`endif

    // Empty chain: first read times out after 256 cycles.
    do_reset();
    nboards = 0;
    pulse_start();
    wait_done("t4_done", 400, cyc);
    check("t4_cycles", cyc, 257);
    check("t4_err", 32'(ERROR), 0);
    check("t4_count", 32'(BOARD_COUNT), 0);
    check("t4_nwr", wr_addr.size(), 0);

    // No ACK on the 0x12 read.
    do_reset();
    nboards = 1;
    set_board(0, 8'hC1, 16'h1234, 8'h56);
    silent_addr = 7'h09;
    pulse_start();
    wait_done("t5_done", 1000, cyc);
    silent_addr = 7'h7F;
    check("t5_err", 32'(ERROR), 1);
    check("t5_count", 32'(BOARD_COUNT), 0);
    check("t5_nwr", wr_addr.size(), 0);
    check("t5_npulse", pulse_base.size(), 0);

    // Reset while waiting on a read, then restart.
    do_reset();
    nboards   = 1;
    rsp_delay = 20;
    pulse_start();
    wait_req("t6_req_up", 10);
    RESETn = 1'b0;
    @(posedge CLK40);
    #1;
    check("t6_req_drop", 32'(AC_REQ), 0);
    check("t6_busy", 32'(BUSY), 0);
    @(negedge CLK40);
    RESETn = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge CLK40);
      if (AC_REQ !== 1'b0) seen++;
    end
    check("t6_quiet", seen, 0);
    clear_log();
    rsp_delay = 2;
    pulse_start();
    wait_req("t6_req_again", 10);
    check("t6_addr", 32'(AC_ADDR), 0);
    check("t6_rnw", 32'(AC_RnW), 1);
    wait_done("t6_done", 2000, cyc);
    check("t6_count", 32'(BOARD_COUNT), 1);
    check("t6_base", 32'(LAST_BASE), 'hE9);
    check("t6_proto", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
